// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and counter-width helper,
// used by uart_rx_frame and the future uart_tx_frame.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } uart_state_e;

    // Width of a counter holding 0..n-1, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Receiver-side bundle: raw serial line in, received word and status out.
interface uart_rx_frame_if #(
    parameter int unsigned DATA_BITS = 9
);
    logic                 i_rx_received;
    logic [DATA_BITS-1:0] o_rx_data;
    logic                 o_rx_done;
    logic                 o_frame_err;
    logic                 o_parity_err;
    logic                 o_busy;

    modport master (
        output i_rx_received,
        input  o_rx_data, o_rx_done, o_frame_err, o_parity_err, o_busy
    );

    modport slave (
        input  i_rx_received,
        output o_rx_data, o_rx_done, o_frame_err, o_parity_err, o_busy
    );
endinterface

// File: rtl/uart_rx_sync.sv
// RX pin synchroniser: SYNC_STAGES flops reset to idle-high, plus a falling-edge strobe.
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic rx_pin,
    output logic rx_s,
    output logic fall_c
);
    logic [SYNC_STAGES-1:0] chain;
    logic                   rx_d;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            chain <= '1;
            rx_d  <= 1'b1;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], rx_pin};
            rx_d  <= chain[SYNC_STAGES-1];
        end
    end

    assign rx_s   = chain[SYNC_STAGES-1];
    assign fall_c = rx_d & ~rx_s;
endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver with false-start rejection, framing/break handling.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int unsigned DIVISOR     = 80,
    parameter int unsigned DATA_BITS   = 9,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PARITY_ODD  = 0
) (
    input  logic            i_clock,
    input  logic            i_reset,
    uart_rx_frame_if.slave  bus
);
    localparam int unsigned BAUD_W = cnt_width(DIVISOR);
    localparam int unsigned BIT_W  = cnt_width(DATA_BITS + 1);
    localparam logic [BAUD_W-1:0] BAUD_MID  = BAUD_W'(DIVISOR / 2 - 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIVISOR - 1);

    if (DIVISOR < 4)                          begin : g_chk_div  $error("DIVISOR must be >= 4");       end
    if (DATA_BITS < 5 || DATA_BITS > 9)       begin : g_chk_data $error("DATA_BITS must be 5..9");     end
    if (STOP_BITS < 1 || STOP_BITS > 2)       begin : g_chk_stop $error("STOP_BITS must be 1 or 2");   end
    if (SYNC_STAGES < 2)                      begin : g_chk_sync $error("SYNC_STAGES must be >= 2");   end
    if (PARITY_ODD > 1)                       begin : g_chk_par  $error("PARITY_ODD must be 0 or 1");  end

    logic                 rx_s;
    logic                 fall_c;
    uart_state_e          state, state_nx;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 ferr_acc;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_done, frame_err, busy;

    logic mid_c, tick_c, last_data_c, last_stop_c;
    logic baud_clr_c, frame_start_c, shift_c, par_c, stop_c, done_c;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .rx_pin  (bus.i_rx_received),
        .rx_s    (rx_s),
        .fall_c  (fall_c)
    );

    assign mid_c       = (baud_cnt == BAUD_MID);
    assign tick_c      = (baud_cnt == BAUD_LAST);
    assign last_data_c = (bit_cnt == BIT_W'(DATA_BITS - 1));
    assign last_stop_c = (bit_cnt == BIT_W'(STOP_BITS - 1));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       if (fall_c) state_nx = START;
            START:      if (mid_c)  state_nx = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:       if (tick_c && last_data_c) state_nx = PARITY;
`else
            DATA:       if (tick_c && last_data_c) state_nx = STOP;
`endif
            PARITY:     if (tick_c) state_nx = STOP;
            // Line still low after the last stop sample means a break: wait it out
            STOP:       if (tick_c && last_stop_c) state_nx = rx_s ? IDLE : BREAK_WAIT;
            BREAK_WAIT: if (rx_s) state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end

    always_comb begin
        baud_clr_c    = 1'b0;
        frame_start_c = 1'b0;
        shift_c       = 1'b0;
        par_c         = 1'b0;
        stop_c        = 1'b0;
        done_c        = 1'b0;
        case (state)
            IDLE: begin
                baud_clr_c    = 1'b1;
                frame_start_c = fall_c;
            end
            START:      baud_clr_c = mid_c;
            DATA:       shift_c    = tick_c;
            PARITY:     par_c      = tick_c;
            STOP: begin
                stop_c = tick_c;
                done_c = tick_c & last_stop_c;
            end
            BREAK_WAIT: baud_clr_c = 1'b1;
            default:    baud_clr_c = 1'b1;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            ferr_acc  <= 1'b0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            baud_cnt <= (baud_clr_c || tick_c) ? '0 : baud_cnt + BAUD_W'(1);

            if (frame_start_c)  bit_cnt <= '0;
            else if (shift_c)   bit_cnt <= last_data_c ? '0 : bit_cnt + BIT_W'(1);
            else if (stop_c)    bit_cnt <= bit_cnt + BIT_W'(1);

            if (shift_c) shreg <= {rx_s, shreg[DATA_BITS-1:1]};

            if (frame_start_c)        ferr_acc <= 1'b0;
            else if (stop_c && !rx_s) ferr_acc <= 1'b1;

            rx_done <= done_c;
            if (done_c) begin
                rx_data   <= shreg;
                frame_err <= ferr_acc | ~rx_s;
            end

            busy <= (state_nx != IDLE);
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit, parity_err;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (par_c)  par_bit <= rx_s;
            if (done_c) parity_err <= par_bit ^ (^shreg) ^ 1'(PARITY_ODD);
        end
    end

    assign bus.o_parity_err = parity_err;
`else
    logic unused_par;
    assign unused_par       = par_c;
    assign bus.o_parity_err = 1'b0;
`endif

    assign bus.o_rx_data   = rx_data;
    assign bus.o_rx_done   = rx_done;
    assign bus.o_frame_err = frame_err;
    assign bus.o_busy      = busy;
endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame (DIVISOR=80, DATA_BITS=9); parity cases run when UART_RX_PARITY_EN is defined.
module tb_uart_rx_frame;
    localparam int BIT_CYC = 80;

    typedef struct {
        logic [8:0] data;
        logic       ferr;
        logic       perr;
        logic       par;
        int         stop_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_done = 0;
    exp_t exp_q[$];
    logic [8:0] last_data = '0;
    logic       last_ferr = 1'b0;
    logic       last_perr = 1'b0;

    uart_rx_frame_if #(.DATA_BITS(9)) bus ();

    uart_rx_frame #(
        .DIVISOR(80), .DATA_BITS(9), .STOP_BITS(1), .SYNC_STAGES(2), .PARITY_ODD(0)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #50 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: every done must match the oldest outstanding frame; outputs hold otherwise
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_rx_done === 1'b1) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_data", 32'(bus.o_rx_data), 32'(e.data));
                    chk("done_ferr", 32'(bus.o_frame_err), 32'(e.ferr));
                    chk("done_perr", 32'(bus.o_parity_err), 32'(e.perr));
                    n_cmp++;
                    if (cyc - e.stop_cyc < 30 || cyc - e.stop_cyc > 60) begin
                        n_bad++;
                        $display("FAIL done_latency: got %0d cycles after stop-bit start, expected 30..60",
                                 cyc - e.stop_cyc);
                    end
                    last_data = e.data;
                    last_ferr = e.ferr;
                    last_perr = e.perr;
                end
            end else begin
                chk("hold_data", 32'(bus.o_rx_data), 32'(last_data));
                chk("hold_ferr", 32'(bus.o_frame_err), 32'(last_ferr));
                chk("hold_perr", 32'(bus.o_parity_err), 32'(last_perr));
            end
        end
    end

    task automatic drive_bit(input logic b);
        bus.i_rx_received = b;
        repeat (BIT_CYC) @(negedge clk);
    endtask

    // Sends start, 9 data bits LSB first, [parity], one stop bit, then gap_bits of idle
    task automatic send_frame(input logic [8:0] data, input logic stop_v, input logic par_v,
                              input int gap_bits);
        exp_t e;
        e.data = data;
        e.ferr = ~stop_v;
        e.par  = par_v;
`ifdef UART_RX_PARITY_EN
        e.perr = par_v ^ (^data);
`else
        e.perr = 1'b0;
`endif
        drive_bit(1'b0);
        for (int i = 0; i < 9; i++) drive_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_v);
`endif
        e.stop_cyc = cyc;
        exp_q.push_back(e);
        drive_bit(stop_v);
        if (gap_bits > 0) begin
            bus.i_rx_received = 1'b1;
            repeat (gap_bits * BIT_CYC) @(negedge clk);
        end
    endtask

    task automatic chk_drained(input string nm);
        chk(nm, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int d0;
        rst = 1'b1;
        bus.i_rx_received = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_data",  32'(bus.o_rx_data), 32'h0);
        chk("reset_done",  32'(bus.o_rx_done), 32'h0);
        chk("reset_ferr",  32'(bus.o_frame_err), 32'h0);
        chk("reset_perr",  32'(bus.o_parity_err), 32'h0);
        chk("reset_busy",  32'(bus.o_busy), 32'h0);
        rst = 1'b0;
        repeat (2 * BIT_CYC) @(negedge clk);

        // 1: single clean frame 1,1,0,0,1,1,0,0,0
        d0 = n_done;
        send_frame(9'b000110011, 1'b1, 1'b0, 2);
        chk("t1_count", 32'(n_done - d0), 32'd1);
        chk("t1_data",  32'(bus.o_rx_data), 32'h033);
        chk("t1_ferr",  32'(bus.o_frame_err), 32'h0);
        chk("t1_busy",  32'(bus.o_busy), 32'h0);
        chk_drained("t1_missing_done");

        // 2: 20-cycle low glitch is rejected at mid-start
        d0 = n_done;
        bus.i_rx_received = 1'b0;
        repeat (20) @(negedge clk);
        bus.i_rx_received = 1'b1;
        repeat (10) @(negedge clk);
        chk("t2_busy_in_start", 32'(bus.o_busy), 32'h1);
        repeat (30) @(negedge clk);
        chk("t2_busy_dropped", 32'(bus.o_busy), 32'h0);
        repeat (2 * BIT_CYC) @(negedge clk);
        chk("t2_no_done", 32'(n_done - d0), 32'd0);

        // 3: stop bit low then break for 5 bit times, then a fresh frame
        d0 = n_done;
        send_frame(9'h0F0, 1'b0, 1'b0, 0);
        repeat (5 * BIT_CYC / 2) @(negedge clk);
        chk("t3_busy_break", 32'(bus.o_busy), 32'h1);
        repeat (5 * BIT_CYC / 2) @(negedge clk);
        chk("t3_one_done", 32'(n_done - d0), 32'd1);
        chk("t3_ferr", 32'(bus.o_frame_err), 32'h1);
        bus.i_rx_received = 1'b1;
        repeat (2 * BIT_CYC) @(negedge clk);
        chk("t3_no_done_on_release", 32'(n_done - d0), 32'd1);
        chk("t3_busy_idle", 32'(bus.o_busy), 32'h0);
        send_frame(9'h101, 1'b1, 1'b0, 2);
        chk("t3_recover_data", 32'(bus.o_rx_data), 32'h101);
        chk("t3_recover_ferr", 32'(bus.o_frame_err), 32'h0);
        chk_drained("t3_missing_done");

        // 4: back-to-back frames with no idle gap
        d0 = n_done;
        send_frame(9'h155, 1'b1, 1'b0, 0);
        send_frame(9'h0AA, 1'b1, 1'b0, 2);
        chk("t4_count", 32'(n_done - d0), 32'd2);
        chk("t4_data", 32'(bus.o_rx_data), 32'h0AA);
        chk_drained("t4_missing_done");

        // 5: reset in the middle of a frame's data bits
        d0 = n_done;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        bus.i_rx_received = 1'b0;
        repeat (40) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_rst_data", 32'(bus.o_rx_data), 32'h0);
        chk("t5_rst_done", 32'(bus.o_rx_done), 32'h0);
        chk("t5_rst_busy", 32'(bus.o_busy), 32'h0);
        chk("t5_rst_ferr", 32'(bus.o_frame_err), 32'h0);
        last_data = '0;
        last_ferr = 1'b0;
        last_perr = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        bus.i_rx_received = 1'b1;
        rst = 1'b0;
        repeat (2 * BIT_CYC) @(negedge clk);
        chk("t5_no_done", 32'(n_done - d0), 32'd0);
        send_frame(9'h1FF, 1'b1, 1'b0, 2);
        chk("t5_count", 32'(n_done - d0), 32'd1);
        chk("t5_data", 32'(bus.o_rx_data), 32'h1FF);
        chk_drained("t5_missing_done");

`ifdef UART_RX_PARITY_EN
        // 6: even parity on 0x003 expects parity bit 0
        send_frame(9'h003, 1'b1, 1'b1, 2);
        chk("t6_perr_bad", 32'(bus.o_parity_err), 32'h1);
        send_frame(9'h003, 1'b1, 1'b0, 2);
        chk("t6_perr_good", 32'(bus.o_parity_err), 32'h0);
        chk_drained("t6_missing_done");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
